// File: rtl/fifo_param.sv
// fifo_param: synchronous single-clock FIFO with occupancy/threshold flags,
// hysteretic upstream pause, and overflow/underflow error indicators.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   Fifo_Data_in    write data (DATA_WIDTH)
//   Fifo_wr         push request
//   Fifo_rd         pop request
//   Fifo_data_out   registered read data, 1-cycle latency, holds when idle
//   Fifo_rd_valid   high for one cycle when Fifo_data_out has a new word
//   Fifo_empty      count == 0
//   Fifo_full       count == DEPTH
//   almost_empty    count <= AE_THRESH
//   almost_full     count >= AF_THRESH
//   pause           upstream hold request (set at AF_THRESH, cleared at AE_THRESH)
//   count           occupancy 0..DEPTH (ADDR_WIDTH+1 bits)
//   error_overflow  push refused because FIFO full
//   error_underflow pop refused because FIFO empty
//
// Build option: define FIFO_STICKY_ERR_EN to make the error outputs latch
// until reset; otherwise each error is a 1-cycle pulse per offending request.

module fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int AE_THRESH  = 1,
    parameter int AF_THRESH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic                  Fifo_wr,
    input  logic                  Fifo_rd,
    output logic [DATA_WIDTH-1:0] Fifo_data_out,
    output logic                  Fifo_rd_valid,
    output logic                  Fifo_empty,
    output logic                  Fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  pause,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  error_overflow,
    output logic                  error_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_THRESH);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic [0:0]            state, state_nxt;
    logic                  push_acc, pop_acc, ovf_det, unf_det;

    // A pop needs a stored word, so a push into an empty FIFO is never
    // popped in the same cycle. A push into a full FIFO is allowed only
    // when a pop frees a slot on the same edge.
    assign pop_acc  = Fifo_rd && (count != '0);
    assign push_acc = Fifo_wr && ((count != FULL_CNT) || pop_acc);
    assign ovf_det  = Fifo_wr && (count == FULL_CNT) && !pop_acc;
    assign unf_det  = Fifo_rd && (count == '0);

    always_comb begin
        count_nxt = count;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = count + (ADDR_WIDTH+1)'(1);
            2'b01:   count_nxt = count - (ADDR_WIDTH+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Hysteresis looks at the next count so pause moves on the same edge
    // that count crosses a threshold.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (count_nxt >= AF_CNT) state_nxt = HOLD;
            HOLD:    if (count_nxt <= AE_CNT) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= Fifo_Data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            Fifo_data_out   <= '0;
            Fifo_rd_valid   <= 1'b0;
            state           <= RUN;
            error_overflow  <= 1'b0;
            error_underflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop_acc) begin
                Fifo_data_out <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + ADDR_WIDTH'(1);
            end
            Fifo_rd_valid <= pop_acc;
            count         <= count_nxt;
            state         <= state_nxt;
`ifdef FIFO_STICKY_ERR_EN
            error_overflow  <= error_overflow  | ovf_det;
            error_underflow <= error_underflow | unf_det;
`else
            error_overflow  <= ovf_det;
            error_underflow <= unf_det;
`endif
        end
    end

    // Flags decode from the registered count, so reset drives them at once.
    assign Fifo_empty   = (count == '0);
    assign Fifo_full    = (count == FULL_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign pause        = (state == HOLD);

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] din = '0;
    logic       wr = 1'b0, rd = 1'b0;
    logic [5:0] Fifo_data_out;
    logic       Fifo_rd_valid, Fifo_empty, Fifo_full, almost_empty, almost_full, pause;
    logic [3:0] count;
    logic       error_overflow, error_underflow;

`ifdef FIFO_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    fifo_param dut (
        .clk(clk), .reset(reset), .Fifo_Data_in(din), .Fifo_wr(wr), .Fifo_rd(rd),
        .Fifo_data_out(Fifo_data_out), .Fifo_rd_valid(Fifo_rd_valid),
        .Fifo_empty(Fifo_empty), .Fifo_full(Fifo_full),
        .almost_empty(almost_empty), .almost_full(almost_full), .pause(pause),
        .count(count), .error_overflow(error_overflow), .error_underflow(error_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [5:0] model [$];
    logic [5:0] exp_q [$];
    logic hold = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Issue one cycle of stimulus; the expected popped word goes to exp_q.
    task automatic step(input logic w, input logic r, input logic [5:0] d);
        logic pop_ok, push_ok;
        pop_ok  = r && (model.size() > 0);
        push_ok = w && ((model.size() < 8) || pop_ok);
        if (pop_ok) exp_q.push_back(model.pop_front());
        if (push_ok) model.push_back(d);
        if (model.size() >= 6) hold = 1'b1;
        else if (model.size() <= 1) hold = 1'b0;
        wr = w; rd = r; din = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        int sz;
        logic [4:0] ef;
        sz = model.size();
        ef = {sz == 0, sz == 8, sz <= 1, sz >= 6, hold};
        chk({tag, "_count"}, 32'(count), 32'(sz));
        chk({tag, "_flags"}, 32'({Fifo_empty, Fifo_full, almost_empty, almost_full, pause}), 32'(ef));
    endtask

    // Monitor: every valid read word must match the scoreboard head.
    always @(negedge clk) begin
        if (Fifo_rd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid", 32'(1), 32'(0));
            else chk("rd_data", 32'(Fifo_data_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_flags", 32'({Fifo_empty, Fifo_full, almost_empty, almost_full, pause}), 32'(5'b10100));
        chk("rst_out", 32'({Fifo_data_out, Fifo_rd_valid, error_overflow, error_underflow}), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Fill and drain, watching flags and pause hysteresis.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 6'(i));
            chk_state("s1_push");
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 6'h00);
            chk_state("s1_pop");
        end
        step(1'b0, 1'b0, 6'h00);

        // Overflow while full.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'h31 + 6'(i));
        step(1'b1, 1'b0, 6'h3F);
        chk("s2_ovf", 32'(error_overflow), 32'(1));
        chk_state("s2");
        step(1'b0, 1'b0, 6'h00);
        chk("s2_ovf_next", 32'(error_overflow), 32'(STICKY));

        // Simultaneous push/pop while full.
        step(1'b1, 1'b1, 6'h2A);
        chk("s4_ovf", 32'(error_overflow), 32'(STICKY));
        chk_state("s4");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00);
        chk("s4_last", 32'(Fifo_data_out), 32'(6'h2A));
        chk_state("s4_end");
        step(1'b0, 1'b0, 6'h00);

        // Underflow while empty.
        step(1'b0, 1'b1, 6'h00);
        chk("s3_unf", 32'(error_underflow), 32'(1));
        chk("s3_valid", 32'(Fifo_rd_valid), 32'(0));
        chk("s3_data_hold", 32'(Fifo_data_out), 32'(6'h2A));
        chk_state("s3");
        step(1'b0, 1'b0, 6'h00);
        chk("s3_unf_next", 32'(error_underflow), 32'(STICKY));

        // Asynchronous reset at count=5 with pause held and a push in flight.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 6'h20 + 6'(i));
        step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b0, 6'h00);
        chk_state("s6_pre");
        wr = 1'b1; din = 6'h15;
        #2 reset = 1'b0;
        #1;
        model.delete();
        hold = 1'b0;
        chk("s6_rst_count", 32'(count), 32'(0));
        chk("s6_rst_flags", 32'({Fifo_empty, Fifo_full, almost_empty, almost_full, pause}), 32'(5'b10100));
        chk("s6_rst_out", 32'({Fifo_data_out, Fifo_rd_valid, error_overflow, error_underflow}), 32'(0));
        wr = 1'b0;
        @(negedge clk) reset = 1'b1;
        step(1'b1, 1'b0, 6'h11);
        chk_state("s6_push");
        step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b0, 6'h00);
        chk("s6_data", 32'(Fifo_data_out), 32'(6'h11));
        chk_state("s6_end");
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, the width of each data word in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, where depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AE_THRESH, default 1, the almost-empty level; the legal range is 0 to DEPTH-1.
REQ-004 The block SHALL have parameter AF_THRESH, default 6, the almost-full level; the legal range is AE_THRESH+1 to DEPTH.
REQ-005 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-007 Fifo_Data_in  input  DATA_WIDTH  the write data.
REQ-008 Fifo_wr  input  1  the push request.
REQ-009 Fifo_rd  input  1  the pop request.
REQ-010 Fifo_data_out  output  DATA_WIDTH  the registered read data.
REQ-011 Fifo_rd_valid  output  1  SHALL pulse high while Fifo_data_out carries a newly popped word.
REQ-012 Fifo_empty, Fifo_full  output  1 each  the occupancy flags.
REQ-013 almost_empty, almost_full  output  1 each  the threshold flags.
REQ-014 pause  output  1  the upstream flow-control request, with hysteresis.
REQ-015 count  output  ADDR_WIDTH+1  the current occupancy, 0 to DEPTH.
REQ-016 error_overflow, error_underflow  output  1 each  the error indicators.

Function
REQ-017 Storage SHALL be a DEPTH x DATA_WIDTH dual-port array with independent write pointer wr_ptr and read pointer rd_ptr, each ADDR_WIDTH bits wide; each pointer SHALL wrap from DEPTH-1 to 0.
REQ-018 A push SHALL be accepted when Fifo_wr=1 and either count<DEPTH, or count=DEPTH and a pop is accepted in the same cycle.
REQ-019 A pop SHALL be accepted when Fifo_rd=1 and count>0; a simultaneous push into an empty FIFO SHALL NOT be popped in that same cycle.
REQ-020 On the edge after an accepted push: the array SHALL store the word at wr_ptr, and wr_ptr SHALL increment.
REQ-021 On the edge after an accepted pop: Fifo_data_out SHALL take the word at rd_ptr, rd_ptr SHALL increment, and Fifo_rd_valid SHALL be 1 for exactly that one cycle.
REQ-022 Read latency SHALL be 1 cycle; Fifo_data_out SHALL hold its last value when no pop is accepted.
REQ-023 count SHALL change by +1 on a push only, by -1 on a pop only, and SHALL remain unchanged when both are accepted.
REQ-024 The flags SHALL be decoded from the registered count as follows: Fifo_empty = (count==0); Fifo_full = (count==DEPTH); almost_empty = (count<=AE_THRESH); almost_full = (count>=AF_THRESH).
REQ-025 pause SHALL be driven by a 2-state FSM with states RUN and HOLD, reset to RUN.
REQ-026 The FSM SHALL go RUN->HOLD when the next count >= AF_THRESH, and HOLD->RUN when the next count <= AE_THRESH.
REQ-027 pause SHALL be 1 in HOLD and 0 in RUN, registered.
REQ-028 Overflow SHALL be detected on Fifo_wr=1 with count==DEPTH and no pop accepted; the word SHALL be dropped and state SHALL remain unchanged.
REQ-029 Underflow SHALL be detected on Fifo_rd=1 with count==0; Fifo_data_out SHALL be unchanged and Fifo_rd_valid SHALL stay 0.
REQ-030 Error outputs SHALL be registered and SHALL assert on the edge following detection.

Reset
REQ-031 While reset=0, the following SHALL be cleared to 0 immediately, independent of clk: wr_ptr, rd_ptr, count, Fifo_data_out, Fifo_rd_valid, Fifo_full, almost_full, pause, error_overflow, error_underflow.
REQ-032 While reset=0, the FSM SHALL be in RUN, and Fifo_empty and almost_empty SHALL be 1.
REQ-033 Array contents SHALL NOT be reset; their values are don't-care.
REQ-034 A reset asserted mid-operation SHALL discard all stored words.
REQ-035 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-036 With macro FIFO_STICKY_ERR_EN defined, error_overflow and error_underflow SHALL stay at 1 after assertion until reset.
REQ-037 With FIFO_STICKY_ERR_EN undefined, each error output SHALL be a 1-cycle pulse per offending request.

Verification
REQ-038 Scenario 1: with defaults, push 8 words 0x01..0x08, then pop 8 -> outputs SHALL be 0x01..0x08 in order, each one cycle after its pop; count SHALL go 8->0; Fifo_full=1 at count=8; Fifo_empty=1 at the end.
REQ-039 Scenario 2: with count=8, Fifo_wr=1 and Fifo_rd=0 -> error_overflow SHALL pulse (macro off) or stick (macro on); count SHALL stay 8; data SHALL be unchanged.
REQ-040 Scenario 3: with count=0, Fifo_rd=1 -> error_underflow SHALL be 1 the next cycle; Fifo_rd_valid=0; count=0.
REQ-041 Scenario 4: with count=8, Fifo_wr=1, Fifo_rd=1 and data 0x2A -> no error; count SHALL stay 8; after 8 further pops the last word out SHALL be 0x2A.
REQ-042 Scenario 5: push to count=6, then pop to count=1 -> pause SHALL rise when count reaches 6, stay 1 at count=5..2, and fall when count reaches 1.
REQ-043 Scenario 6: assert reset at count=5, mid-burst -> all outputs SHALL reach their reset values without a clock edge; after release, push 0x11 and pop -> output SHALL be 0x11.
